// File: rtl/incr_share_arb_pkg.sv
// Shared types and helpers for the incr_share_arb counter block.
// Counter width is three bits per incrementor group.
package incr_share_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int ID_W = $clog2(DEFAULT_NUM_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  function automatic int cw(input int num_groups);
    return 3 * num_groups;
  endfunction

  // Pointer starts at the last requester so requester 0 is searched first.
  function automatic int rr_reset_ptr(input int num_req);
    return num_req - 1;
  endfunction

  localparam int RR_RESET_PTR = rr_reset_ptr(DEFAULT_NUM_REQ);

endpackage

// File: rtl/incr_share_arb_incr.sv
// Combinational N x 3-bit incrementor with a group-level AND-prefix carry.
// all_ones flags an input that is all-ones, i.e. the increment overflows.
module incr_nx3 #(
  parameter int NUM_GROUPS = 4
) (
  input  logic [3*NUM_GROUPS-1:0] a,
  output logic [3*NUM_GROUPS-1:0] sum,
  output logic                    all_ones
);

  logic [NUM_GROUPS-1:0] grp_ones;
  logic [NUM_GROUPS:0]   carry;

  assign carry[0] = 1'b1;

  // A slice increments only when every lower slice is all-ones.
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_slice
    assign grp_ones[gi]       = &a[3*gi +: 3];
    assign carry[gi+1]        = carry[gi] & grp_ones[gi];
    assign sum[3*gi +: 3]     = a[3*gi +: 3] + {2'b00, carry[gi]};
  end

  assign all_ones = carry[NUM_GROUPS];

endmodule

// File: rtl/incr_share_arb.sv
// Round-robin shared incrementor for NUM_REQ private counters, 1-cycle response.
// Optional build macro INCR_SHARE_ARB_SATURATE_EN: counters saturate instead of wrapping.
module incr_share_arb
  import incr_share_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int NUM_GROUPS = 4,
  localparam int CW         = cw(NUM_GROUPS),
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic               clr_valid,
  input  logic [IW-1:0]      clr_id,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [CW-1:0]      rsp_value,
  output logic               rsp_wrap,
  input  logic [IW-1:0]      rd_id,
  output logic [CW-1:0]      rd_value
);

  logic [CW-1:0]      cnt_reg [NUM_REQ];
  logic [IW-1:0]      ptr_reg;
  logic [NUM_REQ-1:0] clr_hit;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [IW-1:0]      grant_idx;
  logic [CW-1:0]      cur_val;
  logic [CW-1:0]      inc_sum;
  logic [CW-1:0]      next_val;
  logic               cur_ones;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % NUM_REQ;
    return IW'(s);
  endfunction

  // A requester being cleared this cycle is not eligible for an increment.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign clr_hit[gi] = clr_valid & (clr_id == IW'(gi));
    assign elig[gi]    = req_valid[gi] & ~clr_hit[gi];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!grant_vld && elig[rr_idx(ptr_reg, off)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx(ptr_reg, off);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign cur_val   = cnt_reg[grant_idx];
  assign rd_value  = cnt_reg[rd_id];

  incr_nx3 #(.NUM_GROUPS(NUM_GROUPS)) u_incr (
    .a        (cur_val),
    .sum      (inc_sum),
    .all_ones (cur_ones)
  );

`ifdef INCR_SHARE_ARB_SATURATE_EN
  assign next_val = cur_ones ? cur_val : inc_sum;
`else
  assign next_val = inc_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_reg[i] <= '0;
      ptr_reg   <= IW'(rr_reset_ptr(NUM_REQ));
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_value <= '0;
      rsp_wrap  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clr_hit[i])    cnt_reg[i] <= '0;
        else if (grant[i]) cnt_reg[i] <= next_val;
      end
      if (grant_vld) ptr_reg <= grant_idx;
      rsp_valid <= grant_vld;
      if (grant_vld) begin
        rsp_id    <= grant_idx;
        rsp_value <= next_val;
        rsp_wrap  <= cur_ones;
      end
    end
  end

endmodule
